// File: rtl/int_ctrl.sv
// int_ctrl: fixed-priority interrupt controller and scheduler in front of CP0 HWInt.
// Optional REQ-state timeout is built in when INT_CTRL_TIMEOUT_EN is defined.
module int_ctrl #(
    parameter int unsigned N_SRC   = 6,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src_in,
    input  logic             reg_we,
    input  logic [1:0]       reg_addr,
    input  logic [31:0]      reg_wdata,
    output logic [31:0]      reg_rdata,
    output logic [N_SRC-1:0] hwint_out,
    input  logic             cp0_ack,
    input  logic             eret,
    output logic             busy
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StService = 2'd2
    } state_e;

    localparam logic [N_SRC-1:0] OneHot = N_SRC'(1);

    state_e           state_q;
    logic [2:0]       grant_q;
    logic [2:0]       win;
    logic [N_SRC-1:0] mode_q;
    logic [N_SRC-1:0] mask_q;
    logic [N_SRC-1:0] pend_q;
    logic [N_SRC-1:0] pend_d;
    logic [N_SRC-1:0] src_prev_q;
    logic [N_SRC-1:0] elig;
    logic [N_SRC-1:0] grant_oh;
    logic [N_SRC-1:0] w1c;
    logic [N_SRC-1:0] auto_clr;
    logic [N_SRC-1:0] edge_set;
    logic             timeout;
    logic             take;
    logic             err;
    logic             unused_cfg;

`ifdef INT_CTRL_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    logic [CntW-1:0] cnt_q;
    logic            err_q;

    assign timeout = (state_q == StReq) && !cp0_ack && (cnt_q == CntW'(TIMEOUT - 1));
    assign err     = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    assign unused_cfg = ^{reg_wdata, 32'(TIMEOUT)};

    always_comb begin
        elig     = pend_q & mask_q;
        grant_oh = OneHot << grant_q;
        win      = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (elig[i]) win = 3'(i);
        end
        w1c      = (reg_we && reg_addr == 2'd2) ? reg_wdata[N_SRC-1:0] : '0;
        take     = (state_q == StReq) && (cp0_ack || timeout);
        auto_clr = take ? (grant_oh & mode_q) : '0;
        edge_set = mode_q & src_in & ~src_prev_q;
        // Edge sources: a new edge beats any same-cycle clear. Level sources follow the line.
        pend_d   = (mode_q & (edge_set | (pend_q & ~(w1c | auto_clr)))) | (~mode_q & src_in);
    end

    always_comb begin
        reg_rdata = '0;
        case (reg_addr)
            2'd0:    reg_rdata = 32'(mode_q);
            2'd1:    reg_rdata = 32'(mask_q);
            2'd2:    reg_rdata = 32'(pend_q);
            default: reg_rdata = {23'd0, err, busy, state_q, 2'b00, grant_q};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            grant_q    <= 3'd0;
            mode_q     <= '0;
            mask_q     <= '0;
            pend_q     <= '0;
            src_prev_q <= '0;
            hwint_out  <= '0;
            busy       <= 1'b0;
`ifdef INT_CTRL_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            if (reg_we && reg_addr == 2'd0) mode_q <= reg_wdata[N_SRC-1:0];
            if (reg_we && reg_addr == 2'd1) mask_q <= reg_wdata[N_SRC-1:0];
            pend_q     <= pend_d;
            src_prev_q <= src_in;
`ifdef INT_CTRL_TIMEOUT_EN
            if (reg_we && reg_addr == 2'd3 && reg_wdata[8]) err_q <= 1'b0;
`endif
            case (state_q)
                StIdle: begin
                    if (|elig) begin
                        state_q   <= StReq;
                        grant_q   <= win;
                        hwint_out <= OneHot << win;
                        busy      <= 1'b1;
`ifdef INT_CTRL_TIMEOUT_EN
                        cnt_q     <= '0;
`endif
                    end
                end
                StReq: begin
                    if (cp0_ack) begin
                        state_q   <= StService;
                        hwint_out <= '0;
                    end else if (timeout) begin
                        state_q   <= StIdle;
                        hwint_out <= '0;
                        busy      <= 1'b0;
`ifdef INT_CTRL_TIMEOUT_EN
                        err_q     <= 1'b1;
`endif
                    end else if (!(|(elig & grant_oh))) begin
                        state_q   <= StIdle;
                        hwint_out <= '0;
                        busy      <= 1'b0;
                    end
`ifdef INT_CTRL_TIMEOUT_EN
                    else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                StService: begin
                    if (eret) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    hwint_out <= '0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed plus randomized checks of int_ctrl against a behavioural model.
module tb_int_ctrl;
    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  src_in = '0;
    logic        reg_we = 1'b0;
    logic [1:0]  reg_addr = '0;
    logic [31:0] reg_wdata = '0;
    logic [31:0] reg_rdata;
    logic [5:0]  hwint_out;
    logic        cp0_ack = 1'b0;
    logic        eret = 1'b0;
    logic        busy;

    always #5 clk = ~clk;

    int_ctrl #(.N_SRC(6), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .src_in    (src_in),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .hwint_out (hwint_out),
        .cp0_ack   (cp0_ack),
        .eret      (eret),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: phase 0 idle, 1 requesting, 2 in service.
    bit [5:0] m_mode, m_mask, m_pend, m_prev;
    int       m_phase = 0;
    int       m_grant = 0;
    int       m_req_cycles = 0;
    bit       m_err = 1'b0;

    function automatic bit [5:0] m_hw();
        bit [5:0] one = 6'b000001;
        return (m_phase == 1) ? (one << m_grant) : 6'b0;
    endfunction

    function automatic bit [31:0] m_read(input bit [1:0] a);
        bit [31:0] r = '0;
        case (a)
            2'd0: r[5:0] = m_mode;
            2'd1: r[5:0] = m_mask;
            2'd2: r[5:0] = m_pend;
            default: begin
                r[8]   = m_err;
                r[7]   = (m_phase != 0);
                r[6:5] = 2'(m_phase);
                r[2:0] = 3'(m_grant);
            end
        endcase
        return r;
    endfunction

    task automatic model_cycle();
        bit [5:0] e;
        bit [5:0] np;
        bit       to;
        bit       take;
        int       g;
        if (reset) begin
            m_mode = '0; m_mask = '0; m_pend = '0; m_prev = '0;
            m_phase = 0; m_grant = 0; m_req_cycles = 0; m_err = 1'b0;
            return;
        end
        e  = m_pend & m_mask;
        to = 1'b0;
`ifdef INT_CTRL_TIMEOUT_EN
        to = (m_phase == 1) && !cp0_ack && (m_req_cycles + 1 >= int'(TO));
`endif
        take = (m_phase == 1) && (cp0_ack || to);
        for (int i = 0; i < 6; i++) begin
            if (m_mode[i]) begin
                if (src_in[i] && !m_prev[i]) np[i] = 1'b1;
                else if ((reg_we && reg_addr == 2'd2 && reg_wdata[i]) || (take && i == m_grant))
                    np[i] = 1'b0;
                else np[i] = m_pend[i];
            end else begin
                np[i] = src_in[i];
            end
        end
        if (reg_we && reg_addr == 2'd3 && reg_wdata[8]) m_err = 1'b0;
        case (m_phase)
            0: if (e != 0) begin
                g = -1;
                for (int i = 0; i < 6; i++) if (e[i] && g < 0) g = i;
                m_grant = g;
                m_phase = 1;
                m_req_cycles = 0;
            end
            1: begin
                if (cp0_ack) m_phase = 2;
                else if (to) begin m_phase = 0; m_err = 1'b1; end
                else if (!e[m_grant]) m_phase = 0;
                else m_req_cycles++;
            end
            default: if (eret) m_phase = 0;
        endcase
        if (reg_we && reg_addr == 2'd0) m_mode = reg_wdata[5:0];
        if (reg_we && reg_addr == 2'd1) m_mask = reg_wdata[5:0];
        m_pend = np;
        m_prev = src_in;
    endtask

    task automatic step();
        model_cycle();
        @(posedge clk);
        #1;
        check("hwint", 32'(hwint_out), 32'(m_hw()));
        check("busy", 32'(busy), 32'(m_phase != 0));
        check("rdata", reg_rdata, m_read(reg_addr));
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        reg_we = 1'b1; reg_addr = a; reg_wdata = d;
        step();
        reg_we = 1'b0; reg_wdata = '0;
    endtask

    task automatic read_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        reg_addr = a;
        #1;
        check(tag, reg_rdata, exp);
    endtask

    initial begin
        step(); step();
        reset = 1'b0;
        check("rst_hw", 32'(hwint_out), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        for (int a = 0; a < 4; a++) read_chk("rst_reg", 2'(a), 32'h0);

        // Level sources, priority to source 0, re-request after eret.
        write_reg(2'd0, 32'h0);
        write_reg(2'd1, 32'h7);
        src_in = 6'b000111;
        step();  check("t1_lat", 32'(hwint_out), 32'h0);
        step();  check("t1_req", 32'(hwint_out), 32'h1);
        check("t1_busy", 32'(busy), 32'h1);
        cp0_ack = 1'b1; step(); cp0_ack = 1'b0;
        check("t1_ack", 32'(hwint_out), 32'h0);
        check("t1_svc_busy", 32'(busy), 32'h1);
        step();
        eret = 1'b1; step(); eret = 1'b0;
        check("t1_eret", 32'(hwint_out), 32'h0);
        step();  check("t1_rereq", 32'(hwint_out), 32'h1);

        // Edge source pulse held until ack, then auto-cleared.
        src_in = '0; reset = 1'b1; step(); reset = 1'b0;
        write_reg(2'd0, 32'h4);
        write_reg(2'd1, 32'h4);
        src_in = 6'b000100; step(); src_in = '0;
        read_chk("t2_pend", 2'd2, 32'h4);
        step();  check("t2_req", 32'(hwint_out), 32'h4);
        repeat (3) step();
        check("t2_hold", 32'(hwint_out), 32'h4);
        cp0_ack = 1'b1; step(); cp0_ack = 1'b0;
        check("t2_ack", 32'(hwint_out), 32'h0);
        read_chk("t2_pend_clr", 2'd2, 32'h0);
        eret = 1'b1; step(); eret = 1'b0;
        repeat (3) step();
        check("t2_idle_hw", 32'(hwint_out), 32'h0);
        check("t2_idle_busy", 32'(busy), 32'h0);

        // W1C of the granted source withdraws the request.
        reset = 1'b1; step(); reset = 1'b0;
        write_reg(2'd0, 32'h4);
        write_reg(2'd1, 32'h4);
        src_in = 6'b000100; step(); src_in = '0;
        step();  check("t3_req", 32'(hwint_out), 32'h4);
        write_reg(2'd2, 32'h4);
        check("t3_w1c_cyc", 32'(hwint_out), 32'h4);
        step();
        check("t3_wd_hw", 32'(hwint_out), 32'h0);
        check("t3_wd_busy", 32'(busy), 32'h0);

        // Edge set beats same-cycle W1C while another source is in service.
        reset = 1'b1; step(); reset = 1'b0;
        write_reg(2'd0, 32'hC);
        write_reg(2'd1, 32'hC);
        src_in = 6'b000100; step(); src_in = '0;
        step();  check("t4_req2", 32'(hwint_out), 32'h4);
        cp0_ack = 1'b1; step(); cp0_ack = 1'b0;
        src_in = 6'b001000; step(); src_in = '0;
        step();
        read_chk("t4_pend_a", 2'd2, 32'h8);
        src_in = 6'b001000; reg_we = 1'b1; reg_addr = 2'd2; reg_wdata = 32'h8;
        step();
        src_in = '0; reg_we = 1'b0; reg_wdata = '0;
        read_chk("t4_pend_b", 2'd2, 32'h8);
        eret = 1'b1; step(); eret = 1'b0;
        check("t4_eret", 32'(hwint_out), 32'h0);
        step();  check("t4_req3", 32'(hwint_out), 32'h8);

        // Reset while in service.
        cp0_ack = 1'b1; step(); cp0_ack = 1'b0;
        check("t5_svc", 32'(busy), 32'h1);
        reset = 1'b1; step();
        check("t5_hw", 32'(hwint_out), 32'h0);
        check("t5_busy", 32'(busy), 32'h0);
        for (int a = 0; a < 4; a++) read_chk("t5_reg", 2'(a), 32'h0);
        reset = 1'b0;

        // REQ without ack: timeout when built in, otherwise waits indefinitely.
        write_reg(2'd0, 32'h4);
        write_reg(2'd1, 32'h4);
        src_in = 6'b000100; step(); src_in = '0;
        step();  check("t6_req", 32'(hwint_out), 32'h4);
`ifdef INT_CTRL_TIMEOUT_EN
        repeat (2) step();
        check("t6_pre", 32'(hwint_out), 32'h4);
        step();
        check("t6_to", 32'(hwint_out), 32'h0);
        read_chk("t6_err", 2'd3, 32'h102);
        write_reg(2'd3, 32'h100);
        read_chk("t6_err_clr", 2'd3, 32'h002);
`else
        repeat (20) step();
        check("t6_wait", 32'(hwint_out), 32'h4);
        read_chk("t6_stat", 2'd3, 32'h0A2);
        write_reg(2'd2, 32'h4);
        step();
`endif

        // Randomized traffic against the model.
        reset = 1'b1; step(); reset = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(3, 0) == 0) src_in = 6'($urandom);
            reg_we    = ($urandom_range(5, 0) == 0);
            reg_addr  = 2'($urandom);
            reg_wdata = $urandom;
            cp0_ack   = ($urandom_range(4, 0) == 0);
            eret      = ($urandom_range(5, 0) == 0);
            reset     = ($urandom_range(299, 0) == 0);
            step();
        end
        reg_we = 1'b0; cp0_ack = 1'b0; eret = 1'b0; reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
Interrupt controller and scheduler in front of CP0's 6-bit HWInt input. It collects raw device interrupt lines, latches them as pending (edge or level per source), applies a mask, and picks one winner by fixed priority. It presents the winner one-hot to CP0, holds the request until CP0 acknowledges, then blocks new requests until the handler returns (eret/EXL clear). Configuration and status registers are bus-accessible from the bridge.

Parameters:
N_SRC, 6, number of interrupt sources; equals CP0 HWInt width.
TIMEOUT, 255, REQ-state cycle limit; used only with INT_CTRL_TIMEOUT_EN.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
src_in  input  N_SRC  raw device interrupt lines, already synchronous to clk.
reg_we  input  1  bus write strobe.
reg_addr  input  2  register select: 0 MODE, 1 MASK, 2 PEND, 3 STAT.
reg_wdata  input  32  bus write data; bits [N_SRC-1:0] used.
reg_rdata  output  32  combinational read data for reg_addr; unused bits 0.
hwint_out  output  N_SRC  one-hot request to CP0 HWInt.
cp0_ack  input  1  single-cycle pulse when CP0 takes the interrupt (its interrupt-response signal).
eret  input  1  single-cycle pulse when the handler returns (CP0 EXL clear).
busy  output  1  high in REQ or SERVICE.

Behaviour:
- Reset: MODE=0 (all level), MASK=0, PEND=0, src_prev=0, state IDLE, grant=0, hwint_out=0, busy=0, STAT error bit=0.
- Edge sources (MODE[i]=1): PEND[i] set at the clock edge where src_in[i]=1 and src_prev[i]=0. Sticky.
- Level sources (MODE[i]=0): PEND[i] <= src_in[i] every cycle (not sticky). W1C and auto-clear have no lasting effect.
- PEND write: write-1-to-clear. Same-cycle edge set and clear: set wins.
- MODE/MASK writes take effect the next cycle. STAT is read-only: {..., err[8], busy[7], state[6:5], 2'b0, grant[2:0]}.
- Eligible vector E = PEND & MASK. Priority: lowest index wins (src 0 highest).
- FSM:
  - IDLE: if E!=0 -> REQ; grant <= index of lowest set bit of E.
  - REQ: hwint_out = 1<<grant, busy=1.
    - cp0_ack -> SERVICE; clear PEND[grant] if it is an edge source.
    - Without ack, E[grant]==0 (masked, W1C, or level dropped) -> IDLE with no ack (withdraw).
    - Ack and withdraw in the same cycle: ack wins.
    - Grant is not re-arbitrated while in REQ, even if a higher-priority source appears.
  - SERVICE: hwint_out=0, busy=1; eret -> IDLE. eret in IDLE/REQ is ignored.
- Latency: src_in rises during cycle t -> PEND set at t+1 -> REQ and hwint_out valid at t+2. From eret to the next REQ: 2 cycles (IDLE for one cycle).
- hwint_out and busy are registered from state/grant. They are never multi-hot.
- Reset asserted mid-REQ/SERVICE: return to IDLE and clear all pending next cycle, with no spurious hwint_out.

Optional Feature:
INT_CTRL_TIMEOUT_EN:
- Defined: an 8+ bit counter runs in REQ, cleared on entering REQ. When the count reaches TIMEOUT with no cp0_ack, the FSM goes to IDLE, sets sticky STAT.err, and clears PEND[grant] if edge. STAT.err is cleared by writing STAT with bit 8=1.
- Undefined: there is no counter, REQ waits indefinitely, and STAT.err reads 0.

Test Plan:
1. MASK=6'b000111, MODE=0, src_in=6'b000111 -> REQ at t+2, hwint_out=6'b000001, busy=1; ack -> hwint_out=0; eret -> after 2 cycles hwint_out=6'b000001 again (level still high).
2. MODE=6'b000100, MASK=6'b000100, pulse src_in[2] for 1 cycle -> PEND=6'b000100; hwint_out=6'b000100 until ack; after ack, PEND=0; eret -> stays IDLE.
3. In REQ with grant=2 (edge), write PEND=6'b000100 (W1C) with no ack -> IDLE next cycle, hwint_out=0, busy=0.
4. Edge src 3 pending in SERVICE; new edge on src 3 in the same cycle as its W1C -> PEND[3] remains 1; after eret, hwint_out=6'b001000.
5. Assert reset while in SERVICE -> next cycle state IDLE, PEND=0, MASK=0, hwint_out=0, reg_rdata at STAT=0.
6. (INT_CTRL_TIMEOUT_EN, TIMEOUT=4) REQ with no ack -> IDLE after 4 REQ cycles, STAT bit8=1; write STAT 0x100 -> bit8=0.
